scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 144 ++++++++++++++
 tb/tb_scan_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit decoder select through up, down, ping-pong or
// single-shot patterns, holding each index for a programmable number of cycles.
module scan_sequencer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       MODE,
  input  logic [DIV_W-1:0] DIV,
  output logic [2:0]       IN,
  output logic             EN,
  output logic             STEP,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] M_UP     = 2'b00;
  localparam logic [1:0] M_DOWN   = 2'b01;
  localparam logic [1:0] M_PP     = 2'b10;
  localparam logic [1:0] M_SINGLE = 2'b11;

  state_t           r_state, w_state;
  logic [DIV_W-1:0] r_presc, w_presc;
  logic [DIV_W-1:0] r_div,   w_div;
  logic [1:0]       r_mode,  w_mode;
  logic             r_dir,   w_dir;   // ping-pong direction, 1 = down
  logic [2:0]       r_idx,   w_idx;
  logic             r_step,  w_step;
  logic             r_done,  w_done;
  logic             r_busy,  w_busy;
  logic             w_tick;

  // Latched divisor is never 0, so DIV-1 cannot underflow and the prescaler never exceeds it.
  assign w_tick = (r_presc == (r_div - DIV_W'(1)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_div   <= DIV_W'(1);
      r_mode  <= M_UP;
      r_dir   <= 1'b0;
      r_idx   <= 3'd0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_presc <= w_presc;
      r_div   <= w_div;
      r_mode  <= w_mode;
      r_dir   <= w_dir;
      r_idx   <= w_idx;
      r_step  <= w_step;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_presc = r_presc;
    w_div   = r_div;
    w_mode  = r_mode;
    w_dir   = r_dir;
    w_idx   = r_idx;
    w_busy  = r_busy;
    w_step  = 1'b0;
    w_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (START && !STOP) begin
          w_state = S_RUN;
          w_mode  = MODE;
          w_div   = (DIV == '0) ? DIV_W'(1) : DIV;
          w_presc = '0;
          w_dir   = 1'b0;
          w_idx   = (MODE == M_DOWN) ? 3'd7 : 3'd0;
          w_step  = 1'b1;
          w_busy  = 1'b1;
        end
      end

      S_RUN: begin
        if (STOP) begin
          w_state = S_IDLE;
          w_presc = '0;
          w_busy  = 1'b0;
        end else if (w_tick) begin
          w_presc = '0;
          w_step  = 1'b1;
          case (r_mode)
            M_UP:   w_idx = r_idx + 3'd1;
            M_DOWN: w_idx = r_idx - 3'd1;
            M_PP: begin
              if (!r_dir) begin
                if (r_idx == 3'd7) begin
                  w_dir = 1'b1;
                  w_idx = 3'd6;
                end else begin
                  w_idx = r_idx + 3'd1;
                end
              end else begin
                if (r_idx == 3'd0) begin
                  w_dir = 1'b0;
                  w_idx = 3'd1;
                end else begin
                  w_idx = r_idx - 3'd1;
                end
              end
            end
            M_SINGLE: begin
              if (r_idx == 3'd7) begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_step  = 1'b0;
                w_done  = 1'b1;
              end else begin
                w_idx = r_idx + 3'd1;
              end
            end
          endcase
        end else begin
          w_presc = r_presc + DIV_W'(1);
        end
      end
    endcase
  end

  assign IN   = r_idx;
  assign EN   = r_busy;
  assign BUSY = r_busy;
  assign STEP = r_step;
  assign DONE = r_done;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed scenarios plus random traffic against an
// index-by-elapsed-time reference model.
module tb_scan_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START, STOP;
  logic [1:0]  MODE;
  logic [15:0] DIV;
  logic [2:0]  IN;
  logic        EN, STEP, BUSY, DONE;

  logic        START4, STOP4;
  logic [3:0]  DIV4;
  logic [2:0]  IN4;
  logic        EN4, STEP4, BUSY4, DONE4;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit         m_run;
  longint     m_n;
  logic [1:0] m_mode;
  longint     m_div;
  logic [2:0] m_in;
  logic       m_step, m_done;

  always #5 CLK = ~CLK;

  scan_sequencer #(.DIV_W(16)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .MODE(MODE), .DIV(DIV),
    .IN(IN), .EN(EN), .STEP(STEP), .BUSY(BUSY), .DONE(DONE)
  );

  scan_sequencer #(.DIV_W(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .START(START4), .STOP(STOP4), .MODE(2'b00), .DIV(DIV4),
    .IN(IN4), .EN(EN4), .STEP(STEP4), .BUSY(BUSY4), .DONE(DONE4)
  );

  // Index shown k periods after start.
  function automatic logic [2:0] seq_val(input logic [1:0] mode, input longint k);
    longint p;
    case (mode)
      2'b00:   return 3'(k % 8);
      2'b01:   return 3'(7 - (k % 8));
      2'b10: begin
        p = k % 14;
        return (p <= 7) ? 3'(p) : 3'(14 - p);
      end
      default: return 3'(k);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_n    = 0;
    m_in   = 3'd0;
    m_step = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_update(input logic st, input logic sp, input logic [1:0] md,
                              input logic [15:0] dv);
    m_done = 1'b0;
    m_step = 1'b0;
    if (!m_run) begin
      if (st && !sp) begin
        m_run  = 1'b1;
        m_n    = 0;
        m_mode = md;
        m_div  = (dv == 16'd0) ? 1 : longint'(dv);
        m_in   = seq_val(m_mode, 0);
        m_step = 1'b1;
      end
    end else if (sp) begin
      m_run = 1'b0;
    end else begin
      m_n++;
      if (m_mode == 2'b11 && m_n == 8 * m_div) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else begin
        m_in   = seq_val(m_mode, m_n / m_div);
        m_step = ((m_n % m_div) == 0);
      end
    end
  endtask

  task automatic check_all();
    chk("in",   16'(IN),   16'(m_in));
    chk("en",   16'(EN),   16'(m_run));
    chk("busy", 16'(BUSY), 16'(m_run));
    chk("step", 16'(STEP), 16'(m_step));
    chk("done", 16'(DONE), 16'(m_done));
  endtask

  // One clock: drive at negedge, model the sampling edge, check 1 time unit later.
  task automatic cyc(input logic st, input logic sp, input logic [1:0] md, input logic [15:0] dv);
    START = st;
    STOP  = sp;
    MODE  = md;
    DIV   = dv;
    @(posedge CLK);
    model_update(st, sp, md, dv);
    #1;
    check_all();
    @(negedge CLK);
  endtask

  initial begin
    RST_N  = 1'b0;
    START  = 1'b0;
    STOP   = 1'b0;
    MODE   = 2'b00;
    DIV    = 16'd0;
    START4 = 1'b0;
    STOP4  = 1'b0;
    DIV4   = 4'hF;
    model_reset();
    repeat (2) @(negedge CLK);
    check_all();
    RST_N = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 2'b00, 16'd3);

    // up-wrap, DIV=3
    cyc(1'b1, 1'b0, 2'b00, 16'd3);
    repeat (30) cyc(1'b0, 1'b0, 2'b00, 16'd3);
    cyc(1'b0, 1'b1, 2'b00, 16'd3);

    // ping-pong, DIV=0 behaves as 1
    cyc(1'b1, 1'b0, 2'b10, 16'd0);
    repeat (20) cyc(1'b0, 1'b0, 2'b10, 16'd0);
    cyc(1'b0, 1'b1, 2'b10, 16'd0);

    // single-shot, DIV=2: runs 16 cycles then DONE
    cyc(1'b1, 1'b0, 2'b11, 16'd2);
    repeat (15) cyc(1'b0, 1'b0, 2'b11, 16'd2);
    cyc(1'b0, 1'b0, 2'b11, 16'd2);
    chk("single_done", 16'(DONE), 16'd1);
    chk("single_in7",  16'(IN),   16'd7);
    repeat (4) cyc(1'b0, 1'b0, 2'b11, 16'd2);

    // down-wrap, DIV=4, stop while IN=5, then START+STOP together
    cyc(1'b1, 1'b0, 2'b01, 16'd4);
    repeat (9) cyc(1'b0, 1'b0, 2'b01, 16'd4);
    cyc(1'b0, 1'b1, 2'b01, 16'd4);
    chk("stop_hold_in", 16'(IN), 16'd5);
    chk("stop_en",      16'(EN), 16'd0);
    repeat (3) cyc(1'b1, 1'b1, 2'b01, 16'd4);
    chk("start_stop_idle", 16'(BUSY), 16'd0);

    // mode/div changes mid-run are ignored
    cyc(1'b1, 1'b0, 2'b00, 16'd5);
    repeat (25) cyc(1'b1, 1'b0, 2'b01, 16'd1);
    cyc(1'b0, 1'b1, 2'b00, 16'd5);

    // asynchronous reset mid-run at IN=4
    cyc(1'b1, 1'b0, 2'b00, 16'd2);
    repeat (8) cyc(1'b0, 1'b0, 2'b00, 16'd2);
    chk("pre_rst_in", 16'(IN), 16'd4);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, 2'b00, 16'd2);

    // maximum divisor on a 4-bit instance: index 0 held 15 cycles
    START4 = 1'b1;
    @(posedge CLK);
    #1;
    START4 = 1'b0;
    chk("max_start_in",   16'(IN4),   16'd0);
    chk("max_start_step", 16'(STEP4), 16'd1);
    for (int i = 1; i <= 15; i++) begin
      @(posedge CLK);
      #1;
      chk("max_in",   16'(IN4),   (i == 15) ? 16'd1 : 16'd0);
      chk("max_step", 16'(STEP4), (i == 15) ? 16'd1 : 16'd0);
    end
    @(negedge CLK);
    STOP4 = 1'b1;
    @(negedge CLK);
    STOP4 = 1'b0;

    // random traffic
    for (int r = 0; r < 3000; r++) begin
      cyc(($urandom % 8) == 0, ($urandom % 40) == 0, 2'($urandom % 4), 16'($urandom % 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
